// File: rtl/bus_timer_if.sv
// Data-bus view of the memory-mapped interval timer.
// The CPU M stage drives address/data/strobe; the timer answers with sel/rdata/intr.
interface bus_timer_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] abus;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic             sel;
    logic [DBITS-1:0] rdata;
    logic             intr;

    modport master (
        output abus,
        output wdata,
        output we,
        input  sel,
        input  rdata,
        input  intr
    );

    modport slave (
        input  abus,
        input  wdata,
        input  we,
        output sel,
        output rdata,
        output intr
    );
endinterface

// File: rtl/bus_timer.sv
// Interval timer on the CPU data bus: TCNT/TLIM/TCTL with a clock prescaler,
// programmable wrap limit, Ready/Overflow flags and a level interrupt.
module bus_timer #(
    parameter int               DBITS  = 32,
    parameter logic [DBITS-1:0] BASE   = 32'hFFFFF100,
    parameter int               CLKDIV = 25000000
) (
    input  logic        clk,
    input  logic        RESET_N,
    bus_timer_if.slave  bus
);

    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLKDIV - 1);

    localparam logic [DBITS-1:0] A_CNT = BASE;
    localparam logic [DBITS-1:0] A_LIM = BASE + DBITS'(4);
    localparam logic [DBITS-1:0] A_CTL = BASE + DBITS'(8);

    logic [PW-1:0]    presc_q, presc_d;
    logic [DBITS-1:0] cnt_q, cnt_d;
    logic [DBITS-1:0] lim_q, lim_d;
    logic             rdy_q, rdy_d;
    logic             ovf_q, ovf_d;
    logic             ie_q, ie_d;

    logic             hit_cnt, hit_lim, hit_ctl;
    logic             wr_cnt, wr_lim, wr_ctl;
    logic             tick, tick_eff, wrap;
    logic             clr0, clr1;
    logic [DBITS-1:0] ctl_rd;

    always_comb begin
        hit_cnt = (bus.abus == A_CNT);
        hit_lim = (bus.abus == A_LIM);
        hit_ctl = (bus.abus == A_CTL);
        wr_cnt  = bus.we & hit_cnt;
        wr_lim  = bus.we & hit_lim;
        wr_ctl  = bus.we & hit_ctl;
    end

    // A TCNT/TLIM write restarts the tick period, so it swallows any tick
    always_comb begin
        tick     = (presc_q == PMAX);
        tick_eff = tick & ~(wr_cnt | wr_lim);
        wrap     = tick_eff & (lim_q != '0) & (cnt_q == lim_q - DBITS'(1));
        clr0     = wr_ctl & ~bus.wdata[0];
        clr1     = wr_ctl & ~bus.wdata[1];
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (wr_cnt | wr_lim | tick) begin
            presc_d = '0;
        end

        cnt_d = cnt_q;
        lim_d = lim_q;
        if (wr_cnt) begin
            cnt_d = bus.wdata;
        end else if (wr_lim) begin
            lim_d = bus.wdata;
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (tick_eff) begin
            cnt_d = cnt_q + DBITS'(1);
        end

        // A wrap landing on a Ready-clear re-arms Ready instead of overflowing
        rdy_d = wrap | (rdy_q & ~clr0);
        ovf_d = (wrap & rdy_q & ~clr0) | (ovf_q & ~clr1);
        ie_d  = wr_ctl ? bus.wdata[8] : ie_q;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        ctl_rd    = '0;
        ctl_rd[8] = ie_q;
        ctl_rd[1] = ovf_q;
        ctl_rd[0] = rdy_q;
    end

    always_comb begin
        bus.sel = hit_cnt | hit_lim | hit_ctl;
        unique case (1'b1)
            hit_cnt: bus.rdata = cnt_q;
            hit_lim: bus.rdata = lim_q;
            hit_ctl: bus.rdata = ctl_rd;
            default: bus.rdata = '0;
        endcase
        bus.intr = ie_q & rdy_q;
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: one CLKDIV=4 instance and one CLKDIV=1 instance,
// expectations queued at stimulus time and popped at each observation.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'hFFFFF100;
    localparam logic [31:0] TCNT = BASE;
    localparam logic [31:0] TLIM = BASE + 32'd4;
    localparam logic [31:0] TCTL = BASE + 32'd8;
    localparam logic [31:0] BAD  = BASE + 32'd12;

    logic clk;
    logic rst_n;

    bus_timer_if #(.DBITS(32)) b4 ();
    bus_timer_if #(.DBITS(32)) b1 ();

    bus_timer #(.DBITS(32), .BASE(BASE), .CLKDIV(4)) u4 (
        .clk     (clk),
        .RESET_N (rst_n),
        .bus     (b4)
    );

    bus_timer #(.DBITS(32), .BASE(BASE), .CLKDIV(1)) u1 (
        .clk     (clk),
        .RESET_N (rst_n),
        .bus     (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int ncomp = 0;
    int nfail = 0;

    task automatic drv(input int w, input logic [31:0] a,
                       input logic [31:0] d, input logic e);
        if (w == 1) begin
            b1.abus = a; b1.wdata = d; b1.we = e;
        end else begin
            b4.abus = a; b4.wdata = d; b4.we = e;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int w, input logic [31:0] a, input logic [31:0] d);
        drv(w, a, d, 1'b1);
        @(posedge clk);
        #1;
        drv(w, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        ncomp++;
        if (exp_q.size() == 0) begin
            nfail++;
            $error("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                nfail++;
                $error("FAIL %s: got %h want %h", tag, obs, e);
            end
        end
    endtask

    task automatic chk_rd(input int w, input string tag,
                          input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        drv(w, a, 32'h0, 1'b0);
        #1;
        cmp(tag, (w == 1) ? b1.rdata : b4.rdata);
    endtask

    task automatic chk_sel(input int w, input string tag,
                           input logic [31:0] a, input logic e);
        exp_q.push_back({31'b0, e});
        drv(w, a, 32'h0, 1'b0);
        #1;
        cmp(tag, {31'b0, (w == 1) ? b1.sel : b4.sel});
    endtask

    task automatic chk_intr(input int w, input string tag, input logic e);
        exp_q.push_back({31'b0, e});
        #1;
        cmp(tag, {31'b0, (w == 1) ? b1.intr : b4.intr});
    endtask

    initial begin
        rst_n = 1'b0;
        drv(4, 32'h0, 32'h0, 1'b0);
        drv(1, 32'h0, 32'h0, 1'b0);
        step(2);
        rst_n = 1'b1;

        // get some state going, then reset mid-count
        wr(4, TLIM, 32'd5);
        wr(4, TCTL, 32'h100);
        step(9);
        rst_n = 1'b0;
        #1;
        chk_rd(4, "rst_tcnt", TCNT, 32'h0);
        chk_rd(4, "rst_tlim", TLIM, 32'h0);
        chk_rd(4, "rst_tctl", TCTL, 32'h0);
        chk_intr(4, "rst_intr", 1'b0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk_rd(4, "post_rst_3", TCNT, 32'd0);
        step(1);
        chk_rd(4, "post_rst_tick", TCNT, 32'd1);

        // wrap at limit 3
        wr(4, TLIM, 32'd3);
        chk_rd(4, "wrap_cnt0", TCNT, 32'd0);
        chk_rd(4, "wrap_ctl0", TCTL, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(4);
            chk_rd(4, "wrap_cnt", TCNT, 32'((i + 1) % 3));
            chk_rd(4, "wrap_ctl", TCTL, (i == 2) ? 32'h1 : 32'h0);
        end

        // second wrap without clearing Ready -> Overflow
        step(12);
        chk_rd(4, "ovf_ctl", TCTL, 32'h3);
        chk_intr(4, "ovf_intr_ie0", 1'b0);
        wr(4, TCTL, 32'h0);
        chk_rd(4, "ovf_clr", TCTL, 32'h0);

        // interrupt
        wr(4, TCTL, 32'h100);
        wr(4, TLIM, 32'd2);
        step(7);
        chk_intr(4, "intr_pre", 1'b0);
        step(1);
        chk_intr(4, "intr_wrap", 1'b1);
        chk_rd(4, "intr_ctl", TCTL, 32'h101);
        wr(4, TCTL, 32'h102);
        chk_intr(4, "intr_clr", 1'b0);
        chk_rd(4, "intr_ctl2", TCTL, 32'h100);

        // Ready-clear landing on a wrap edge
        wr(4, TLIM, 32'd2);
        step(8);
        chk_rd(4, "col_rdy", TCTL, 32'h101);
        step(7);
        wr(4, TCTL, 32'h100);
        chk_rd(4, "col_ctl", TCTL, 32'h101);
        chk_rd(4, "col_cnt", TCNT, 32'd0);

        // TCNT write on a tick edge
        wr(4, TLIM, 32'd0);
        step(3);
        wr(4, TCNT, 32'd7);
        chk_rd(4, "tcnt_wr", TCNT, 32'd7);
        step(3);
        chk_rd(4, "tcnt_hold", TCNT, 32'd7);
        step(1);
        chk_rd(4, "tcnt_tick", TCNT, 32'd8);
        chk_rd(4, "tcnt_flags", TCTL, 32'h101);

        // decode
        wr(4, BAD, 32'h55);
        chk_sel(4, "bad_sel", BAD, 1'b0);
        chk_rd(4, "bad_rd", BAD, 32'h0);
        chk_rd(4, "bad_lim", TLIM, 32'h0);
        chk_rd(4, "bad_ctl", TCTL, 32'h101);
        chk_sel(4, "lim_sel", TLIM, 1'b1);

        // free-run rollover, CLKDIV=1
        wr(1, TCNT, 32'hFFFFFFFF);
        chk_rd(1, "fr_max", TCNT, 32'hFFFFFFFF);
        step(1);
        chk_rd(1, "fr_roll", TCNT, 32'h0);
        chk_rd(1, "fr_ctl", TCTL, 32'h0);
        step(1);
        chk_rd(1, "fr_next", TCNT, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
